pixel_stream_fifo: RTL and testbench

Buffers the incoming video pixel stream and delivers one 12-bit RGB pixel per active-video cycle to the VGA output stage. It sits directly upstream of the VGA timing core. It accepts pixels over a valid/ready handshake with a start-of-frame marker, and consumes the timing core's `drawing_pixels` and `v_sync`. It aligns frames to the display raster, pre-fills before streaming, and substitutes black on underflow.

---
 rtl/pixel_stream_fifo.sv | 181 ++++++++++++++++++
 tb/tb_pixel_stream_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pixel_stream_fifo - show-ahead pixel FIFO aligning source frames to the VGA raster.
// Define PIXEL_FIFO_STATS_EN for underflow/sync-error counters. Rev 1.0
// -----------------------------------------------------------------------------
module pixel_stream_fifo #(
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 512,
  parameter int LW      = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  input  logic        s_sof,
  input  logic        drawing_pixels,
  input  logic        v_sync,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        streaming,
  output logic [15:0] underflow_cnt,
  output logic [15:0] sync_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

  localparam logic [1:0] SEEK   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          vs_prev;
  logic          frame_pending;

  logic          push;
  logic          pop;
  logic          show;
  logic          fp;
  logic          underflow_evt;
  logic          sync_err_evt;
  logic [12:0]   head;
  logic          head_sof;
  logic          not_empty;
  logic          prefilled;

  assign s_ready   = (level < DEPTH_L);
  assign push      = s_valid & s_ready;
  assign head      = mem[rd_ptr];
  assign head_sof  = head[12];
  assign not_empty = (level != '0);
  assign prefilled = (level >= PREFILL_L);
  assign fp        = drawing_pixels & frame_pending;
  assign streaming = (state == STREAM);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_sof, s_data};
  end

  // Full/empty come from level only; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_prev       <= 1'b1;
      frame_pending <= 1'b0;
    end else begin
      vs_prev <= v_sync;
      if (drawing_pixels)
        frame_pending <= 1'b0;
      else if (!vs_prev && v_sync)
        frame_pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    show          = 1'b0;
    underflow_evt = 1'b0;
    sync_err_evt  = 1'b0;
    case (state)
      SEEK: begin
        if (not_empty) begin
          if (head_sof) state_nxt = ARMED;
          else          pop       = 1'b1;
        end
      end
      ARMED: begin
        if (fp && prefilled && not_empty) begin
          pop       = 1'b1;
          show      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (drawing_pixels) begin
          if (fp) begin
            if (not_empty && head_sof) begin
              pop  = 1'b1;
              show = 1'b1;
            end else begin
              sync_err_evt = 1'b1;
              state_nxt    = SEEK;
            end
          end else if (!not_empty) begin
            underflow_evt = 1'b1;
          end else if (head_sof) begin
            // Source frame ended early: hold its successor's sof word for the next FP.
            sync_err_evt = 1'b1;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
      default: state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEEK;
      r     <= 4'h0;
      g     <= 4'h0;
      b     <= 4'h0;
    end else begin
      state <= state_nxt;
      r     <= show ? head[11:8] : 4'h0;
      g     <= show ? head[7:4]  : 4'h0;
      b     <= show ? head[3:0]  : 4'h0;
    end
  end

`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] underflow_q;
  logic [15:0] sync_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow_q <= 16'h0;
      sync_err_q  <= 16'h0;
    end else begin
      if (underflow_evt && (underflow_q != 16'hFFFF)) underflow_q <= underflow_q + 16'd1;
      if (sync_err_evt  && (sync_err_q  != 16'hFFFF)) sync_err_q  <= sync_err_q + 16'd1;
    end
  end

  assign underflow_cnt = underflow_q;
  assign sync_err_cnt  = sync_err_q;
`else
  logic unused_stats;
  assign unused_stats  = underflow_evt ^ sync_err_evt;
  assign underflow_cnt = 16'h0;
  assign sync_err_cnt  = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_fifo.sv
`default_nettype none
// Directed bench for pixel_stream_fifo on a reduced FIFO (16 deep, prefill 8)
// with hand-driven raster strobes.
module tb_pixel_stream_fifo;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
`ifdef PIXEL_FIFO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        s_sof;
  logic        drawing_pixels;
  logic        v_sync;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        streaming;
  logic [15:0] underflow_cnt;
  logic [15:0] sync_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] drain_exp [16];

  pixel_stream_fifo #(
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_sof          (s_sof),
    .drawing_pixels (drawing_pixels),
    .v_sync         (v_sync),
    .r              (r),
    .g              (g),
    .b              (b),
    .streaming      (streaming),
    .underflow_cnt  (underflow_cnt),
    .sync_err_cnt   (sync_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; return 1 time unit after the edge that consumed them.
  task automatic cyc(input logic v, input logic [11:0] d, input logic sof,
                     input logic dp, input logic vs);
    s_valid        = v;
    s_data         = d;
    s_sof          = sof;
    drawing_pixels = dp;
    v_sync         = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 12'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [11:0] d, input logic sof);
    cyc(1'b1, d, sof, 1'b0, 1'b1);
  endtask

  task automatic draw();
    cyc(1'b0, 12'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vpulse();
    cyc(1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 12'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    drain_exp = '{12'h703, 12'h704, 12'h705, 12'h706, 12'h707,
                  12'h800, 12'h801, 12'h802, 12'h803, 12'h804, 12'h805,
                  12'h806, 12'h807, 12'h808, 12'h809, 12'h80A};
    reset          = 1'b0;
    s_valid        = 1'b0;
    s_data         = 12'h0;
    s_sof          = 1'b0;
    drawing_pixels = 1'b0;
    v_sync         = 1'b1;
    repeat (3) idle();
    check("rst_rgb", {r, g, b}, 12'h0);
    check("rst_streaming", streaming, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    check("rst_underflow", underflow_cnt, 16'h0);
    check("rst_syncerr", sync_err_cnt, 16'h0);
    reset = 1'b1;
    idle();

    // Frame 1: 10 words ahead of the raster, then stream with an underflow tail.
    for (int i = 0; i < 10; i++) push(12'(12'h210 + i), (i == 0));
    check("armed_not_streaming", streaming, 1'b0);
    check("ready_partial", s_ready, 1'b1);
    vpulse();
    idle();
    check("pre_fp_black", {r, g, b}, 12'h0);
    for (int i = 0; i < 6; i++) begin
      draw();
      check($sformatf("f1_px%0d", i), {r, g, b}, 12'(12'h210 + i));
    end
    check("stream_rise", streaming, 1'b1);
    idle();
    check("hblank_black", {r, g, b}, 12'h0);
    for (int i = 6; i < 10; i++) begin
      draw();
      check($sformatf("f1_px%0d", i), {r, g, b}, 12'(12'h210 + i));
    end
    for (int i = 0; i < 2; i++) begin
      draw();
      check($sformatf("starved_%0d", i), {r, g, b}, 12'h0);
    end
    check("underflow_cnt", underflow_cnt, 32'(2 * STATS));
    check("underflow_keeps_stream", streaming, 1'b1);

    // Next source frame arrives while the raster frame is still active.
    push(12'h3A0, 1'b1);
    push(12'h3A1, 1'b0);
    push(12'h3A2, 1'b0);
    draw();
    check("short_frame_black", {r, g, b}, 12'h0);
    check("short_frame_syncerr", sync_err_cnt, 32'(STATS));
    check("short_frame_streaming", streaming, 1'b1);
    vpulse();
    draw();
    check("f2_px0", {r, g, b}, 12'h3A0);
    draw();
    check("f2_px1", {r, g, b}, 12'h3A1);

    // FP with a non-sof head drops to SEEK, which discards up to the next sof.
    vpulse();
    draw();
    check("fp_nosof_black", {r, g, b}, 12'h0);
    check("fp_nosof_syncerr", sync_err_cnt, 32'(2 * STATS));
    check("fp_nosof_seek", streaming, 1'b0);
    for (int i = 1; i <= 3; i++) push(12'(12'hEE0 + i), 1'b0);
    for (int i = 0; i < 9; i++) push(12'(12'h5C0 + i), (i == 0));
    check("seek_armed_not_streaming", streaming, 1'b0);
    vpulse();
    draw();
    check("f3_px0", {r, g, b}, 12'h5C0);
    check("f3_streaming", streaming, 1'b1);
    draw();
    check("f3_px1", {r, g, b}, 12'h5C1);

    // Asynchronous reset in the middle of an active line.
    drawing_pixels = 1'b1;
    reset = 1'b0;
    #2;
    check("midrst_rgb", {r, g, b}, 12'h0);
    check("midrst_streaming", streaming, 1'b0);
    check("midrst_ready", s_ready, 1'b1);
    check("midrst_syncerr", sync_err_cnt, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();

    // Level PREFILL-1 at FP: frame stays black until a later FP with enough data.
    for (int i = 0; i < 7; i++) push(12'(12'h700 + i), (i == 0));
    vpulse();
    for (int i = 0; i < 3; i++) begin
      draw();
      check($sformatf("underfilled_px%0d", i), {r, g, b}, 12'h0);
    end
    check("underfilled_not_streaming", streaming, 1'b0);
    push(12'h707, 1'b0);
    vpulse();
    draw();
    check("prefilled_px0", {r, g, b}, 12'h700);
    check("prefilled_streaming", streaming, 1'b1);

    // Fill to DEPTH, reject a push when full, then simultaneous push/pop at DEPTH-1.
    for (int i = 0; i < 9; i++) push(12'(12'h800 + i), 1'b0);
    check("full_not_ready", s_ready, 1'b0);
    cyc(1'b1, 12'hBAD, 1'b0, 1'b0, 1'b1);
    check("full_reject_not_ready", s_ready, 1'b0);
    cyc(1'b1, 12'h809, 1'b0, 1'b1, 1'b1);
    check("full_pop_px", {r, g, b}, 12'h701);
    check("nonfull_ready", s_ready, 1'b1);
    cyc(1'b1, 12'h809, 1'b0, 1'b1, 1'b1);
    check("pushpop_px", {r, g, b}, 12'h702);
    check("pushpop_ready", s_ready, 1'b1);
    cyc(1'b1, 12'h80A, 1'b0, 1'b0, 1'b1);
    check("refull_not_ready", s_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      draw();
      check($sformatf("drain_px%0d", i), {r, g, b}, 32'(drain_exp[i]));
    end
    draw();
    check("drain_empty_black", {r, g, b}, 12'h0);
    check("drain_underflow", underflow_cnt, 32'(STATS));
    check("drain_syncerr", sync_err_cnt, 16'h0);

    // Reset while full and streaming: ready returns without waiting for a clock.
    for (int i = 0; i < 16; i++) push(12'(12'h900 + i), 1'b0);
    check("full2_not_ready", s_ready, 1'b0);
    drawing_pixels = 1'b1;
    reset = 1'b0;
    #2;
    check("fullrst_ready", s_ready, 1'b1);
    check("fullrst_streaming", streaming, 1'b0);
    check("fullrst_rgb", {r, g, b}, 12'h0);
    check("fullrst_underflow", underflow_cnt, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    check("post_rst_ready", s_ready, 1'b1);
    check("post_rst_streaming", streaming, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
